// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 compression core, one round per accepted schedule word, K ROM inside.
module sha256_compress (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_hash_in,
  input  logic [31:0]  i_w,
  input  logic         i_w_valid,
  output logic         o_w_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic [255:0] o_hash
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  state_t state_q, state_d;
  logic [5:0] t_q, t_d;
  logic [7:0][31:0] v_q, v_d, h_q, h_d, hash_q, hash_d;
  logic done_q, done_d;
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
  // v_q[7] holds a and v_q[0] holds h, matching the H0-in-MSBs packing
  assign {a, b, c, d, e, f, g, h} = v_q;
  assign t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t_q] + i_w;
  assign t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    v_d = v_q;
    h_d = h_q;
    hash_d = hash_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        h_d = i_hash_in;
        v_d = i_hash_in;
        t_d = 6'd0;
        state_d = ROUND;
      end
      ROUND: if (i_w_valid) begin
        v_d = {t1 + t2, a, b, c, d + t1, e, f, g};
        t_d = t_q + 6'd1;
        state_d = t_q == 6'd63 ? FINAL : ROUND;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) hash_d[i] = h_q[i] + v_q[i];
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      t_q <= '0;
      v_q <= '0;
      h_q <= '0;
      hash_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      v_q <= v_d;
      h_q <= h_d;
      hash_q <= hash_d;
      done_q <= done_d;
    end
  end
  assign o_w_ready = state_q == ROUND;
  assign o_busy = state_q != IDLE;
  assign o_done = done_q;
  assign o_hash = hash_q;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: randomized and known-answer checks of sha256_compress against a block-level model.
module tb_sha256_compress;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_w_valid = 1'b0;
  logic [255:0] i_hash_in = '0;
  logic [31:0] i_w = '0;
  logic o_w_ready, o_busy, o_done;
  logic [255:0] o_hash;
  int checks = 0, errors = 0, done_cnt = 0;
  typedef logic [31:0] wa_t [64];
  wa_t ws, w2;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  sha256_compress dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_hash_in(i_hash_in),
    .i_w(i_w), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .o_busy(o_busy),
    .o_done(o_done), .o_hash(o_hash)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_done) done_cnt++;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic build(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) ws[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      ws[i] = (rotr(ws[i-2], 17) ^ rotr(ws[i-2], 19) ^ (ws[i-2] >> 10)) + ws[i-7]
            + (rotr(ws[i-15], 7) ^ rotr(ws[i-15], 18) ^ (ws[i-15] >> 3)) + ws[i-16];
  endtask
  function automatic logic [255:0] compress(input logic [255:0] iv, input wa_t w);
    logic [31:0] v [8], hv [8], t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) hv[i] = iv[255 - 32 * i -: 32];
    v = hv;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hv[i] + v[i];
    return r;
  endfunction
  task automatic run_block(input logic [255:0] iv, input wa_t w, input int stalls, input int start_at,
                           input bit b2b, output logic [255:0] dig, output int lat);
    int idx, st_left, rdy_bad, n;
    bit seen;
    if (!b2b) begin
      @(posedge i_clk);
      #1;
    end
    i_start = 1'b1;
    i_hash_in = iv;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_hash_in = rnd256();
    idx = 0; st_left = stalls; rdy_bad = 0; n = 0; seen = 0;
    while (idx < 64) begin
      i_start = idx == start_at;
      if (i_start) i_hash_in = rnd256();
      if (st_left > 0 && ($urandom_range(0, 1) == 1 || idx == 63)) begin
        i_w_valid = 1'b0;
        i_w = $urandom;
        st_left--;
      end else begin
        i_w_valid = 1'b1;
        i_w = w[idx];
        idx++;
      end
      @(negedge i_clk);
      if (!o_w_ready || !o_busy) rdy_bad++;
      @(posedge i_clk);
      n++;
      #1;
    end
    i_start = 1'b0;
    i_w_valid = 1'b0;
    i_w = $urandom;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge i_clk);
      if (o_done) seen = 1;
      else begin
        @(posedge i_clk);
        n++;
      end
    end
    check("w_ready_in_round", rdy_bad, 0);
    check("done_seen", seen, 1);
    dig = o_hash;
    lat = n;
  endtask
  initial begin
    logic [255:0] dig, d1, iv;
    int lat, base, d0, st;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_hash", o_hash, 0);
    check("rst_done", o_done, 0);
    check("rst_ready", o_w_ready, 0);
    check("rst_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    build(ABC_BLK);
    run_block(IV, ws, 0, -1, 0, dig, lat);
    check("abc_digest", dig, ABC_DIG);
    check("abc_model", dig, compress(IV, ws));
    check("abc_latency", lat, 65);
    base = lat;
    @(negedge i_clk);
    check("done_pulse", o_done, 0);
    check("hash_hold", o_hash, ABC_DIG);
    build(EMPTY_BLK);
    run_block(IV, ws, 0, -1, 0, dig, lat);
    check("empty_digest", dig, EMPTY_DIG);
    build(ABC_BLK);
    run_block(IV, ws, 37, -1, 0, dig, lat);
    check("stall_digest", dig, ABC_DIG);
    check("stall_latency", lat, base + 37);
    run_block(IV, ws, 0, 10, 0, dig, lat);
    check("busy_start_digest", dig, ABC_DIG);
    build(EMPTY_BLK);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_hash_in = IV;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_w_valid = 1'b1;
      i_w = ws[k];
      @(posedge i_clk);
      #1;
    end
    i_w_valid = 1'b0;
    i_rst = 1'b1;
    d0 = done_cnt;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("abort_hash", o_hash, 0);
    check("abort_busy", o_busy, 0);
    check("abort_ready", o_w_ready, 0);
    repeat (80) @(posedge i_clk);
    check("abort_no_done", done_cnt, d0);
    run_block(IV, ws, 0, -1, 0, dig, lat);
    check("after_abort_digest", dig, EMPTY_DIG);
    build(ABC_BLK);
    run_block(IV, ws, 0, -1, 0, d1, lat);
    check("b2b_first", d1, ABC_DIG);
    build({rnd256(), rnd256()});
    w2 = ws;
    run_block(d1, w2, 0, -1, 1, dig, lat);
    check("b2b_second", dig, compress(d1, w2));
    check("b2b_latency", lat, 65);
    for (int r = 0; r < 4; r++) begin
      iv = rnd256();
      build({rnd256(), rnd256()});
      st = $urandom_range(0, 12);
      run_block(iv, ws, st, -1, 0, dig, lat);
      check("rand_digest", dig, compress(iv, ws));
      check("rand_latency", lat, 65 + st);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
